// File: rtl/bit_serializer_pkg.sv
// Shared constants for the lab's FSM blocks: state encodings and default word width.
// No ports; imported by bit_serializer.
package bit_serializer_pkg;

  // State encodings are fixed so that other blocks decoding state stay compatible.
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter: loads a WIDTH-bit word and emits it one bit per cycle on x,
// MSB or LSB first. Streams back-to-back when a new word is loaded during the final bit.
// Ports: clk/reset (async, active-high); load/din in; x, ready, busy, done, bit_idx, frames_sent out.
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic             x,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [3:0]       bit_idx,
  output logic [7:0]       frames_sent
);

  localparam logic [3:0] LAST_IDX = 4'(WIDTH - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_shifted;
  logic             accept;

  // The bit on x is always the outgoing end of the shift register, so x is a flop
  // output. The register is cleared when a word ends, which keeps x=0 while idle.
  generate
    if (MSB_FIRST) begin : g_msb
      assign x            = sreg[WIDTH-1];
      assign sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
    end else begin : g_lsb
      assign x            = sreg[0];
      assign sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
    end
  endgenerate

  assign busy   = (state == SHIFT);
  assign done   = busy && (bit_idx == LAST_IDX);
  // The final-bit cycle also accepts a load so consecutive words have no gap.
  assign ready  = !busy || done;
  assign accept = load && ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_idx <= 4'd0;
    end else if (accept) begin
      state   <= SHIFT;
      sreg    <= din;
      bit_idx <= 4'd0;
    end else if (done) begin
      state   <= IDLE;
      sreg    <= '0;
      bit_idx <= 4'd0;
    end else if (busy) begin
      sreg    <= sreg_shifted;
      bit_idx <= bit_idx + 4'd1;
    end
  end

  // Counts words whose final bit went out; wraps naturally at 8 bits.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frames_sent <= 8'd0;
    end else if (done) begin
      frames_sent <= frames_sent + 8'd1;
    end
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer: directed scenarios plus randomized traffic checked
// against a queue-of-bits reference model. A second instance covers LSB-first order.
module tb_bit_serializer;

  localparam int W = 8;

  logic       clk;
  logic       reset;
  logic       load;
  logic [7:0] din;
  logic       x, ready, busy, done;
  logic [3:0] bit_idx;
  logic [7:0] frames_sent;

  logic       load2;
  logic [7:0] din2;
  logic       x2, ready2, busy2, done2;
  logic [3:0] bit_idx2;
  logic [7:0] frames_sent2;

  int checks = 0;
  int errors = 0;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .load(load), .din(din),
    .x(x), .ready(ready), .busy(busy), .done(done),
    .bit_idx(bit_idx), .frames_sent(frames_sent)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .load(load2), .din(din2),
    .x(x2), .ready(ready2), .busy(busy2), .done(done2),
    .bit_idx(bit_idx2), .frames_sent(frames_sent2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a queue of (bit value, bit index) still to appear on x.
  int   mq_bit[$];
  int   mq_idx[$];
  int   m_frames;
  logic exp_x, exp_busy, exp_done, exp_ready;
  logic [3:0] exp_idx;
  logic [7:0] exp_frames;

  task automatic model_reset();
    mq_bit.delete();
    mq_idx.delete();
    m_frames = 0;
  endtask

  task automatic model_expect();
    if (mq_bit.size() == 0) begin
      exp_x = 1'b0; exp_busy = 1'b0; exp_done = 1'b0; exp_idx = 4'd0; exp_ready = 1'b1;
    end else begin
      exp_x     = mq_bit[0][0];
      exp_busy  = 1'b1;
      exp_idx   = 4'(mq_idx[0]);
      exp_done  = (mq_idx[0] == W - 1);
      exp_ready = exp_done;
    end
    exp_frames = 8'(m_frames);
  endtask

  // Applies one rising edge worth of behaviour for the given inputs.
  task automatic model_update(input logic l, input logic [7:0] d);
    logic rdy;
    rdy = (mq_bit.size() == 0) || (mq_idx[0] == W - 1);
    if (mq_bit.size() != 0) begin
      if (mq_idx[0] == W - 1) m_frames = (m_frames + 1) % 256;
      void'(mq_bit.pop_front());
      void'(mq_idx.pop_front());
    end
    if (l && rdy) begin
      for (int k = 0; k < W; k++) begin
        mq_bit.push_back(int'(d[W - 1 - k]));
        mq_idx.push_back(k);
      end
    end
  endtask

  // Consumes the edge for the currently driven inputs, drives new inputs for the next
  // cycle, and stops at the following falling edge with model expectations prepared.
  task automatic tick(input logic l, input logic [7:0] d);
    model_update(load, din);
    @(posedge clk);
    #1;
    load = l;
    din  = d;
    @(negedge clk);
    model_expect();
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b0; din = 8'h00; load2 = 1'b0; din2 = 8'h00;
    #3;
    checks++;
    if (x !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || bit_idx !== 4'd0 ||
        frames_sent !== 8'd0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: x=%b busy=%b done=%b idx=%0d frames=%0d ready=%b, required 0 0 0 0 0 1",
               x, busy, done, bit_idx, frames_sent, ready);
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    // Load must be taken on the very first edge after release.
    load = 1'b1;
    din  = 8'h96;
    tick(1'b0, 8'h00);
    checks++;
    if (x !== 1'b1 || busy !== 1'b1 || bit_idx !== 4'd0) begin
      errors++;
      $display("FAIL first_edge_load: x=%b busy=%b idx=%0d, required 1 1 0", x, busy, bit_idx);
    end
    for (int i = 0; i < 12 && exp_busy; i++) tick(1'b0, 8'h00);
  endtask

  task automatic test_single_word();
    logic [7:0] w;
    logic [7:0] f0;
    w = 8'b1011_0010;
    tick(1'b1, w);
    f0 = exp_frames;
    checks++;
    if (ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: ready=%b busy=%b, required 1 0", ready, busy);
    end
    for (int k = 0; k < W; k++) begin
      tick(1'b0, 8'($urandom));
      checks++;
      if (x !== w[W-1-k] || busy !== 1'b1 || bit_idx !== 4'(k) || done !== (k == W - 1)) begin
        errors++;
        $display("FAIL single_bit%0d: x=%b busy=%b idx=%0d done=%b, required %b 1 %0d %b",
                 k, x, busy, bit_idx, done, w[W-1-k], k, (k == W - 1));
      end
    end
    tick(1'b0, 8'h00);
    checks++;
    if (busy !== 1'b0 || x !== 1'b0 || done !== 1'b0 || frames_sent !== f0 + 8'd1) begin
      errors++;
      $display("FAIL single_end: busy=%b x=%b done=%b frames=%0d, required 0 0 0 %0d",
               busy, x, done, frames_sent, f0 + 8'd1);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stream;
    int          done_at[$];
    stream = 16'hA53C;
    tick(1'b1, 8'hA5);
    for (int k = 0; k < 2 * W; k++) begin
      tick(k == W - 1, (k == W - 1) ? 8'h3C : 8'($urandom));
      if (done === 1'b1) done_at.push_back(k);
      checks++;
      if (x !== stream[15-k] || busy !== 1'b1 || bit_idx !== 4'(k % W)) begin
        errors++;
        $display("FAIL b2b_bit%0d: x=%b busy=%b idx=%0d, required %b 1 %0d",
                 k, x, busy, bit_idx, stream[15-k], k % W);
      end
    end
    checks++;
    if (done_at.size() != 2 || done_at[0] != W - 1 || done_at[1] != 2 * W - 1) begin
      errors++;
      $display("FAIL b2b_done: pulses=%0d, required 2 at bit 7 and 15", done_at.size());
    end
    tick(1'b0, 8'h00);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: busy=%b, required 0", busy);
    end
  endtask

  task automatic test_load_while_busy();
    logic [7:0] f0;
    tick(1'b1, 8'h00);
    f0 = exp_frames;
    for (int k = 0; k < W; k++) begin
      tick(k == 3, (k == 3) ? 8'hFF : 8'($urandom));
      checks++;
      if (x !== 1'b0 || busy !== 1'b1 || (k == 3 && ready !== 1'b0)) begin
        errors++;
        $display("FAIL busy_load_bit%0d: x=%b busy=%b ready=%b, required 0 1 %b",
                 k, x, busy, ready, (k == W - 1));
      end
    end
    tick(1'b0, 8'h00);
    tick(1'b0, 8'h00);
    checks++;
    if (busy !== 1'b0 || frames_sent !== f0 + 8'd1) begin
      errors++;
      $display("FAIL busy_load_end: busy=%b frames=%0d, required 0 %0d", busy, frames_sent, f0 + 8'd1);
    end
  endtask

  task automatic test_reset_mid_word();
    bit found;
    found = 1'b0;
    tick(1'b1, 8'hFF);
    for (int i = 0; i < 20 && !found; i++) begin
      tick(1'b0, 8'h00);
      if (exp_idx == 4'd4) found = 1'b1;
    end
    checks++;
    if (!found || bit_idx !== 4'd4) begin
      errors++;
      $display("FAIL midreset_reach: idx=%0d, required 4", bit_idx);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if (x !== 1'b0 || busy !== 1'b0 || bit_idx !== 4'd0 || frames_sent !== 8'd0 ||
        done !== 1'b0 || ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_async: x=%b busy=%b idx=%0d frames=%0d done=%b ready=%b, required 0 0 0 0 0 1",
               x, busy, bit_idx, frames_sent, done, ready);
    end
    model_reset();
    load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < W; i++) begin
      tick(1'b0, 8'h00);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || frames_sent !== 8'd0) begin
        errors++;
        $display("FAIL midreset_after%0d: done=%b busy=%b frames=%0d, required 0 0 0",
                 i, done, busy, frames_sent);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      tick(($urandom % 3) == 0, 8'($urandom));
      checks++;
      if (x !== exp_x || busy !== exp_busy || done !== exp_done || bit_idx !== exp_idx ||
          ready !== exp_ready || frames_sent !== exp_frames) begin
        errors++;
        $display("FAIL random_cyc%0d: x=%b busy=%b done=%b idx=%0d ready=%b frames=%0d, required %b %b %b %0d %b %0d",
                 i, x, busy, done, bit_idx, ready, frames_sent,
                 exp_x, exp_busy, exp_done, exp_idx, exp_ready, exp_frames);
      end
    end
    for (int i = 0; i < 12 && exp_busy; i++) tick(1'b0, 8'h00);
  endtask

  task automatic test_wrap();
    int dones;
    dones = 0;
    reset = 1'b1;
    load  = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tick(1'b1, 8'($urandom));
    for (int i = 0; i < 256 * W + 4 && dones < 256; i++) begin
      tick(1'b1, 8'($urandom));
      if (done === 1'b1) dones++;
      if (exp_done && frames_sent !== exp_frames) begin
        checks++;
        errors++;
        $display("FAIL wrap_count: frames=%0d, required %0d", frames_sent, exp_frames);
      end
    end
    load = 1'b0;
    tick(1'b0, 8'h00);
    checks++;
    if (dones != 256 || frames_sent !== 8'd0) begin
      errors++;
      $display("FAIL wrap_zero: dones=%0d frames=%0d, required 256 0", dones, frames_sent);
    end
    for (int i = 0; i < 12 && exp_busy; i++) tick(1'b0, 8'h00);
  endtask

  task automatic test_lsb_first();
    @(posedge clk);
    #1;
    load2 = 1'b1;
    din2  = 8'b0000_0001;
    @(posedge clk);
    #1;
    load2 = 1'b0;
    din2  = 8'hFF;
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      checks++;
      if (x2 !== (k == 0) || busy2 !== 1'b1 || bit_idx2 !== 4'(k)) begin
        errors++;
        $display("FAIL lsb_bit%0d: x=%b busy=%b idx=%0d, required %b 1 %0d",
                 k, x2, busy2, bit_idx2, (k == 0), k);
      end
    end
    @(negedge clk);
    checks++;
    if (busy2 !== 1'b0 || x2 !== 1'b0) begin
      errors++;
      $display("FAIL lsb_end: busy=%b x=%b, required 0 0", busy2, x2);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_load_while_busy();
    test_reset_mid_word();
    test_random();
    test_wrap();
    test_lsb_first();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits, legal range 2..16.
REQ-002 SHALL have parameter MSB_FIRST, default 1: 1 = shift MSB first, 0 = shift LSB first.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous reset, active-high.
REQ-005 SHALL have port load, input, 1 bit: request to accept din; honoured only when ready=1.
REQ-006 SHALL have port din, input, WIDTH bits: parallel word to serialize.
REQ-007 SHALL have port x, output, 1 bit: registered serial bit stream, fed to the downstream sequence detector input.
REQ-008 SHALL have port ready, output, 1 bit: load will be accepted this cycle.
REQ-009 SHALL have port busy, output, 1 bit: x carries a valid data bit this cycle.
REQ-010 SHALL have port done, output, 1 bit: one-cycle pulse coincident with the final bit of a word.
REQ-011 SHALL have port bit_idx, output, 4 bits: index of the bit currently on x, 0..WIDTH-1.
REQ-012 SHALL have port frames_sent, output, 8 bits: count of completed words.

Function
REQ-013 SHALL implement FSM states IDLE and SHIFT.
- IDLE -> SHIFT on load=1.
- SHIFT -> IDLE after the bit with bit_idx=WIDTH-1 when load=0.
- SHIFT -> SHIFT on the last bit with load=1.
REQ-014 SHALL drive ready=1 in IDLE and during the final bit of SHIFT, and 0 otherwise (combinational from state and bit_idx).
REQ-015 SHALL capture din into the shift register on the rising edge that samples load=1 with ready=1 (cycle N).
REQ-016 SHALL present data bit k on x during cycle N+1+k, k=0..WIDTH-1.
- MSB_FIRST=1: k=0 is din[WIDTH-1].
- MSB_FIRST=0: k=0 is din[0].
REQ-017 SHALL hold busy=1 for exactly cycles N+1..N+WIDTH and bit_idx=k during cycle N+1+k.
REQ-018 SHALL assert done=1 only in cycle N+WIDTH.
REQ-019 SHALL increment frames_sent by 1 on the edge ending cycle N+WIDTH, modulo 256 (255 -> 0).
REQ-020 SHALL give back-to-back streaming when load=1 in a final-bit cycle: next word's bit 0 appears the following cycle, with no gap and busy staying 1.
REQ-021 SHALL ignore load while ready=0; din changes while busy SHALL NOT affect bits in flight.
REQ-022 SHALL hold x=0, busy=0, done=0, bit_idx=0 in IDLE.

Reset
REQ-023 SHALL, on reset=1 (asynchronous, active-high), immediately force state=IDLE, shift register=0, x=0, busy=0, done=0, bit_idx=0, frames_sent=0; ready=1 follows combinationally.
REQ-024 SHALL, on reset mid-word, abandon the word with no done pulse and no frames_sent increment.
REQ-025 SHALL accept load on the first rising edge after reset deasserts.

Structure
REQ-026 SHALL take state encodings (IDLE=1'b0, SHIFT=1'b1) and the default WIDTH from a shared constants include file used by the lab's FSM blocks.
REQ-027 SHALL be a single module; no sub-module is required.

Verification
REQ-028 Single word: din=8'b1011_0010, load at N -> x=1,0,1,1,0,0,1,0 in cycles N+1..N+8; done only at N+8; frames_sent=1.
REQ-029 Back-to-back: load 8'hA5, then load 8'h3C at the final-bit cycle -> 16 contiguous bits 10100101 00111100; busy never drops; two done pulses 8 cycles apart.
REQ-030 Load while busy: load=1 with din=8'hFF at bit_idx=3 of word 8'h00 -> x stays 0 for all 8 bits; frames_sent increments by exactly 1.
REQ-031 Reset mid-word: reset asserted at bit_idx=4 -> x=0, busy=0, bit_idx=0, frames_sent=0 immediately, before the next clock edge; no done pulse.
REQ-032 Wrap and order: 256 words -> frames_sent returns to 0; MSB_FIRST=0 with din=8'b0000_0001 -> x=1 in the first bit cycle only.
